// File: rtl/game_screen_ctrl_pkg.sv
// Shared screen-controller types and helpers, also used by LED/debug and top-level blocks.
package game_screen_ctrl_pkg;

   // Screen FSM encoding; ST_BAD is never entered on purpose and recovers to ST_START.
   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_PLAY  = 2'd1,
      ST_OVER  = 2'd2,
      ST_BAD   = 2'd3
   } screen_state_t;

   // Largest of three frame limits, used to size the shared frame counter.
   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/game_screen_ctrl_if.sv
// Signal bundle between the screen controller and game logic / video mixer.
interface game_screen_ctrl_if;
   logic       startKey;
   logic       frameTick;
   logic       gameOver;
   logic       startDR;
   logic       startDRout;
   logic       gameEn;
   logic       gameRestart;
   logic [1:0] screenState;

   // Master side drives the raw inputs and observes the controller outputs.
   modport master (
      output startKey, frameTick, gameOver, startDR,
      input  startDRout, gameEn, gameRestart, screenState
   );

   // Slave side is the controller itself.
   modport slave (
      input  startKey, frameTick, gameOver, startDR,
      output startDRout, gameEn, gameRestart, screenState
   );
endinterface

// File: rtl/key_edge_detect.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous push button.
module key_edge_detect (
   input  logic clk,
   input  logic resetN,
   input  logic key,
   output logic press
);
   logic sync1_q, sync2_q, prev_q;

   // Synchronize the raw level and keep one delayed copy for edge detection.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= key;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // One-clk pulse per press.
   assign press = sync2_q & ~prev_q;

endmodule

// File: rtl/game_screen_ctrl.sv
// Start / play / game-over screen sequencer with blinking start-screen gate.
module game_screen_ctrl
   import game_screen_ctrl_pkg::*;
#(
   parameter int unsigned BLINK_FRAMES = 30,
   parameter int unsigned OVER_FRAMES  = 180,
   parameter int unsigned ARM_FRAMES   = 15
) (
   input logic               clk,
   input logic               resetN,
   game_screen_ctrl_if.slave bus
);
   localparam int unsigned CNT_MAX = max3(BLINK_FRAMES, OVER_FRAMES, ARM_FRAMES);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);

   localparam logic [CNT_W-1:0]   CNT_SAT    = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0]   ARM_LAST   = CNT_W'(ARM_FRAMES - 1);
   localparam logic [CNT_W-1:0]   OVER_LAST  = CNT_W'(OVER_FRAMES - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

   screen_state_t      state_q, state_d;
   logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blink_q, blink_d;
   logic               armed_q, armed_d;
   logic               game_en_q, restart_q;
   logic               key_press;
   logic               state_change;

   key_edge_detect u_key_edge (
      .clk    (clk),
      .resetN (resetN),
      .key    (bus.startKey),
      .press  (key_press)
   );

   assign state_change = (state_d != state_q);

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= ST_START;
         frame_cnt_q <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b1;
         armed_q     <= 1'b0;
         game_en_q   <= 1'b0;
         restart_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
         armed_q     <= armed_d;
         game_en_q   <= (state_d == ST_PLAY);
         restart_q   <= (state_d == ST_PLAY) && (state_q != ST_PLAY);
      end
   end

   // Next-state decision; gameOver beats a simultaneous key press since keys are ignored in play.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_START: if (armed_q && key_press) state_d = ST_PLAY;
         ST_PLAY:  if (bus.gameOver) state_d = ST_OVER;
         ST_OVER:  if (bus.frameTick && (frame_cnt_q == OVER_LAST)) state_d = ST_START;
         default:  state_d = ST_START;
      endcase
   end

   // Frame/blink counters; a tick on the clk of a state change is dropped, not carried over.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      armed_d     = armed_q;
      if (state_change) begin
         frame_cnt_d = '0;
         blink_cnt_d = '0;
         blink_d     = 1'b1;
         armed_d     = 1'b0;
      end else if (bus.frameTick) begin
         if (frame_cnt_q != CNT_SAT) frame_cnt_d = frame_cnt_q + 1'b1;
         if (state_q == ST_START) begin
            if (frame_cnt_q == ARM_LAST) armed_d = 1'b1;
            if (blink_cnt_q == BLINK_LAST) begin
               blink_cnt_d = '0;
               blink_d     = ~blink_q;
            end else begin
               blink_cnt_d = blink_cnt_q + 1'b1;
            end
         end
      end
   end

   // Outputs; startDRout stays combinational so the pixel path gains no latency.
   always_comb begin
      bus.startDRout  = bus.startDR & (state_q == ST_START) & blink_q;
      bus.gameEn      = game_en_q;
      bus.gameRestart = restart_q;
      bus.screenState = state_q;
   end

endmodule
